// File: rtl/imm_splitter.sv
// imm_splitter
//   Narrows a 32-bit constant into one or two 16-bit immediate beats. Each
//   beat carries the extension mode the decode-stage extender applies:
//     2'b00 sign-extend, 2'b01 zero-on-low (upper load), 2'b10 zero-on-high.
//   A two-beat pair is 01/high half, then 10/low half (OR-combined).
//
// Optional feature: define IMM_SPLIT_SIGNED_EN to enable mode 00, so small
//   negatives (v[31:15] all ones) take a single sign-extended beat.
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high
//   in_valid     in_value is presented
//   in_ready     block accepts in_value this cycle (combinational)
//   in_value     32-bit constant to split
//   out_valid    out_imm/out_mode/out_last hold a beat
//   out_ready    consumer takes the beat this cycle
//   out_imm      16-bit immediate field
//   out_mode     extension mode of this beat
//   out_last     beat completes the constant
//   split_count  saturating count of constants that needed two beats
module imm_splitter (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_imm,
  output logic [1:0]  out_mode,
  output logic        out_last,
  output logic [15:0] split_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_HIGH   = 2'd2,
    ST_LOW    = 2'd3
  } state_t;

  localparam logic [1:0] MODE_SEXT = 2'b00;
  localparam logic [1:0] MODE_ZLO  = 2'b01;
  localparam logic [1:0] MODE_ZHI  = 2'b10;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 16'd1;
    end
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [15:0] hold_r;
  logic [15:0] hold_s;
  logic        valid_s;
  logic [15:0] imm_s;
  logic [1:0]  mode_s;
  logic        last_s;
  logic [15:0] count_s;

  logic        two_s;
  logic [15:0] cls_imm_s;
  logic [1:0]  cls_mode_s;
  logic        accept_s;
  logic        xfer_s;

  // Ready only when no beat is pending, or the last pending beat leaves now.
  assign in_ready = (state_r == ST_IDLE) ||
                    (((state_r == ST_SINGLE) || (state_r == ST_LOW)) && out_ready);
  assign accept_s = in_valid && in_ready;
  assign xfer_s   = out_valid && out_ready;

  // Classify the presented value; the first beat's imm/mode come from here.
  always_comb begin
    two_s      = 1'b0;
    cls_imm_s  = in_value[15:0];
    cls_mode_s = MODE_ZHI;
    if (in_value[31:16] == 16'h0000) begin
      cls_imm_s  = in_value[15:0];
      cls_mode_s = MODE_ZHI;
    end
`ifdef IMM_SPLIT_SIGNED_EN
    else if (&in_value[31:15]) begin
      cls_imm_s  = in_value[15:0];
      cls_mode_s = MODE_SEXT;
    end
`endif
    else if (in_value[15:0] == 16'h0000) begin
      cls_imm_s  = in_value[31:16];
      cls_mode_s = MODE_ZLO;
    end else begin
      two_s      = 1'b1;
      cls_imm_s  = in_value[31:16];
      cls_mode_s = MODE_ZLO;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_s = state_r;
    valid_s = out_valid;
    imm_s   = out_imm;
    mode_s  = out_mode;
    last_s  = out_last;
    hold_s  = hold_r;
    count_s = split_count;
    case (state_r)
      ST_IDLE, ST_SINGLE, ST_LOW: begin
        // In SINGLE/LOW an accept implies the current beat transfers too.
        if (accept_s) begin
          valid_s = 1'b1;
          imm_s   = cls_imm_s;
          mode_s  = cls_mode_s;
          if (two_s) begin
            state_s = ST_HIGH;
            last_s  = 1'b0;
            hold_s  = in_value[15:0];
            count_s = sat_inc(split_count);
          end else begin
            state_s = ST_SINGLE;
            last_s  = 1'b1;
          end
        end else if (xfer_s) begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_HIGH: begin
        if (xfer_s) begin
          state_s = ST_LOW;
          imm_s   = hold_r;
          mode_s  = MODE_ZHI;
          last_s  = 1'b1;
        end else begin
          state_s = ST_HIGH;
        end
      end
      default: begin
        state_s = ST_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, holding register and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      hold_r      <= 16'h0000;
      out_valid   <= 1'b0;
      out_imm     <= 16'h0000;
      out_mode    <= 2'b00;
      out_last    <= 1'b0;
      split_count <= 16'h0000;
    end else begin
      state_r     <= state_s;
      hold_r      <= hold_s;
      out_valid   <= valid_s;
      out_imm     <= imm_s;
      out_mode    <= mode_s;
      out_last    <= last_s;
      split_count <= count_s;
    end
  end

endmodule

// File: tb/tb_imm_splitter.sv
// Self-checking bench for imm_splitter: directed cases followed by random
// traffic, all compared against a beat-queue reference model.
module tb_imm_splitter;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_mode;
  logic        out_last;
  logic [15:0] split_count;

  imm_splitter dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_mode    (out_mode),
    .out_last    (out_last),
    .split_count (split_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          exp_cnt;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the beat list a constant must produce.
  task automatic push_beats(input logic [31:0] v);
    beat_t b;
    if (v[31:16] == 16'h0000) begin
      b = '{v[15:0], 2'b10, 1'b1}; exp_q.push_back(b);
    end
`ifdef IMM_SPLIT_SIGNED_EN
    else if (v[31:15] == 17'h1FFFF) begin
      b = '{v[15:0], 2'b00, 1'b1}; exp_q.push_back(b);
    end
`endif
    else if (v[15:0] == 16'h0000) begin
      b = '{v[31:16], 2'b01, 1'b1}; exp_q.push_back(b);
    end else begin
      b = '{v[31:16], 2'b01, 1'b0}; exp_q.push_back(b);
      b = '{v[15:0], 2'b10, 1'b1}; exp_q.push_back(b);
      if (exp_cnt < 65535) exp_cnt++;
    end
  endtask

  // One clock cycle: drive, check at negedge, then advance the model.
  task automatic step(input logic v, input logic [31:0] val, input logic r);
    logic  exp_ready;
    logic  acc;
    logic  xf;
    beat_t h;
    in_valid  = v;
    in_value  = val;
    out_ready = r;
    @(negedge clock);
    exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && r);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check("split_count", {16'd0, split_count}, exp_cnt[31:0]);
    if (exp_q.size() != 0) begin
      h = exp_q[0];
      check("out_imm", {16'd0, out_imm}, {16'd0, h.imm});
      check("out_mode", {30'd0, out_mode}, {30'd0, h.mode});
      check("out_last", {31'd0, out_last}, {31'd0, h.last});
    end
    acc = v && exp_ready;
    xf  = (exp_q.size() != 0) && r;
    @(posedge clock);
    #1;
    if (xf) void'(exp_q.pop_front());
    if (acc) push_beats(val);
  endtask

  logic [31:0] rv;
  logic [31:0] rval;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    exp_cnt   = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_value  = 32'h0000_0000;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_imm", {16'd0, out_imm}, 32'd0);
    check("rst_out_mode", {30'd0, out_mode}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_split_count", {16'd0, split_count}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Small positive, negative, upper-only, full split.
    step(1'b1, 32'h0000_8001, 1'b1);
    step(1'b1, 32'hFFFF_FFFE, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h1234_0000, 1'b1);
    step(1'b1, 32'h1234_5678, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Stall in HIGH for 3 cycles with a competing input presented.
    step(1'b1, 32'hABCD_1111, 1'b1);
    step(1'b1, 32'h0000_0042, 1'b0);
    step(1'b1, 32'h0000_0042, 1'b0);
    step(1'b1, 32'h0000_0042, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Back-to-back singles, no bubble.
    step(1'b1, 32'h0000_0001, 1'b1);
    step(1'b1, 32'h0000_0002, 1'b1);
    step(1'b1, 32'h0000_0003, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Reset while in LOW.
    step(1'b1, 32'h1234_5678, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    reset = 1'b1;
    #2;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_split_count", {16'd0, split_count}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_last", {31'd0, out_last}, 32'd0);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    step(1'b1, 32'h5555_0000, 1'b1);
    step(1'b1, 32'h0000_00AB, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Random traffic across all value classes and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      rv = $urandom;
      case ($urandom_range(0, 3))
        0:       rval = {16'h0000, rv[15:0]};
        1:       rval = {16'hFFFF, rv[15:0]};
        2:       rval = {rv[31:16], 16'h0000};
        default: rval = rv;
      endcase
      step($urandom_range(0, 3) != 0, rval, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
